int_ctrl_wb: RTL and testbench
==============================

Name: int_ctrl_wb

Overview:
- Wishbone-slave interrupt controller that sits directly downstream of the timer and other peripherals.
- Collects their irq lines (the timer irq occupies source 0 by convention) into pending, enable and master-enable registers.
- Drives one combined, registered interrupt request to the processor core.
- Software services a source by acknowledging it here and clearing the source's own flag (e.g. the timer ISR bit).

Parameters:
- INT_NUM, 8, number of interrupt sources (1..32)
- Dw, 32, wishbone data width (>= INT_NUM)
- Aw, 3, wishbone address width (word address)
- SELw, 4, wishbone byte-select width (ignored; full-word access only)
- TAGw, 3, wishbone tag width (ignored)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- sa_dat_i  in  Dw  write data
- sa_sel_i  in  SELw  byte select (unused)
- sa_addr_i  in  Aw  register word address
- sa_tag_i  in  TAGw  tag (unused)
- sa_stb_i  in  1  strobe
- sa_cyc_i  in  1  cycle (unused)
- sa_we_i  in  1  write enable
- sa_dat_o  out  Dw  registered read data
- sa_ack_o  out  1  acknowledge
- sa_err_o  out  1  constant 0
- sa_rty_o  out  1  constant 0
- irq_i  in  INT_NUM  source interrupt lines, synchronous to clk, active-high
- irq_o  out  1  combined interrupt to CPU, registered

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk. Reset clears every register: mer, ier, edge, pending, irq_q, sa_dat_o, sa_ack_o, irq_o all 0.
- Register map (word address):
  - 0 MER: bit0 master enable.
  - 1 IER: per-source enable.
  - 2 IAR: write 1 clears pending bit; reads 0.
  - 3 IPR: pending, read-only; writes ignored.
  - 4 EDGE: 1 = rising-edge, 0 = level.
  - 5 VEC: optional feature.
  - 6-7: read 0, writes ignored.
- Wishbone: sa_ack_o <= sa_stb_i & ~sa_ack_o, giving a 1-cycle ack latency and a minimum 2-cycle access.
  - A write commits once, in the cycle with stb & we & ~ack.
  - Read data is loaded into sa_dat_o on stb & ~we & ~ack and held otherwise.
  - Read-data bits above INT_NUM are 0.
- irq_q <= irq_i every cycle.
- Per-source set event:
  - edge mode: set = irq_i & ~irq_q.
  - level mode: set = irq_i.
- pending_next = (pending & ~iar_clr) | set. Set wins over a simultaneous IAR clear, so an event is never lost.
- In level mode, acking while the line is still high re-pends the source; software must clear the source first.
- Pending latches regardless of IER or MER. Masking only gates irq_o.
- irq_o <= mer & |(pending_next & ier). A source event reaches irq_o on the clock edge after it is presented, i.e. 1 cycle of latency.
- Writing EDGE takes effect for events from the following cycle. irq_q continues sampling regardless of mode.
- Reading IPR in the same cycle as a set event returns the pre-update value.
- Asynchronous reset mid-transaction drops ack. The master must restart the access.

Optional Feature:
- Macro INT_CTRL_VECTOR_EN.
- When defined:
  - Address 5 VEC reads the index of the lowest-numbered bit of pending & ier.
  - Bit Dw-1 is set when there is no such bit (index field then 0).
  - Writing VEC with value n clears pending[n] (n < INT_NUM; ignored otherwise). Same set-wins rule as IAR.
- When not defined: address 5 reads 0 and writes are ignored; no priority logic is synthesized.

Decomposition:
- Shared package/header holds the register address constants MER/IER/IAR/IPR/EDGE/VEC and the VEC "none" flag position.
- One natural sub-module, int_prio_enc: INT_NUM-input lowest-index priority encoder with valid output. It is instantiated only under INT_CTRL_VECTOR_EN.

Test Plan:
- Reset, then read all addresses 0-7 -> every read returns 0; irq_o=0; each ack arrives exactly one cycle after stb.
- MER=1, IER=0x01, EDGE=0; pulse irq_i[0] for 1 cycle -> IPR=0x01 and irq_o=1 one cycle later, and it stays 1. Write IAR=0x01 while the line is low -> IPR=0, irq_o=0.
- Level mode: hold irq_i[2]=1, IER=0x04, write IAR=0x04 -> IPR bit2 is still 1 next cycle. Drop irq_i[2], then write IAR=0x04 -> IPR=0.
- Edge mode on source 3 (EDGE=0x08): hold irq_i[3] high for 10 cycles, ack once -> IPR bit3 stays 0 (no re-trigger). A new rising edge in the same cycle as an IAR write -> bit3 stays 1.
- Masking: IER=0, pulse irq_i[5] -> IPR=0x20, irq_o=0. Set IER=0x20 with MER=0 -> irq_o=0. Set MER=1 -> irq_o=1 next cycle.
- INT_CTRL_VECTOR_EN: pending=0x28 with IER=0xFF -> VEC=3. Write VEC=3 -> VEC=5. Write IAR=0x20 -> VEC=0x80000000.

Source files
------------

// File: rtl/int_ctrl_wb_pkg.sv
// Shared register map and helpers for the int_ctrl_wb interrupt controller.
`timescale 1ns/1ps
package int_ctrl_wb_pkg;

  typedef enum logic [2:0] {
    REG_MER  = 3'd0,
    REG_IER  = 3'd1,
    REG_IAR  = 3'd2,
    REG_IPR  = 3'd3,
    REG_EDGE = 3'd4,
    REG_VEC  = 3'd5
  } reg_addr_e;

  // Bit of the VEC read value that flags "no enabled source pending".
  function automatic int vec_none_bit(input int dw);
    return dw - 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_ctrl_wb_if.sv
// Wishbone slave-port signal bundle for int_ctrl_wb.
`timescale 1ns/1ps
interface int_ctrl_wb_if #(
  parameter int Dw   = 32,
  parameter int Aw   = 3,
  parameter int SELw = 4,
  parameter int TAGw = 3
);
  logic [Dw-1:0]   sa_dat_i;
  logic [SELw-1:0] sa_sel_i;
  logic [Aw-1:0]   sa_addr_i;
  logic [TAGw-1:0] sa_tag_i;
  logic            sa_stb_i;
  logic            sa_cyc_i;
  logic            sa_we_i;
  logic [Dw-1:0]   sa_dat_o;
  logic            sa_ack_o;
  logic            sa_err_o;
  logic            sa_rty_o;

  modport master (
    output sa_dat_i, sa_sel_i, sa_addr_i, sa_tag_i, sa_stb_i, sa_cyc_i, sa_we_i,
    input  sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
  );

  modport slave (
    input  sa_dat_i, sa_sel_i, sa_addr_i, sa_tag_i, sa_stb_i, sa_cyc_i, sa_we_i,
    output sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
  );
endinterface

// File: rtl/int_ctrl_wb_prio_enc.sv
// Lowest-index-first priority encoder; used for the VEC register.
`timescale 1ns/1ps
module int_prio_enc #(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic [N-1:0]    req,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  // NOTE: every output gets a default before the loop, so no latch is inferred.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDXW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl_wb.sv
// Wishbone-slave interrupt controller with pending/enable/master-enable registers.
// Optional vectored readout and clear via VEC is built when INT_CTRL_VECTOR_EN is defined.
`timescale 1ns/1ps
module int_ctrl_wb
  import int_ctrl_wb_pkg::*;
#(
  parameter int INT_NUM = 8,
  parameter int Dw      = 32,
  parameter int Aw      = 3,
  parameter int SELw    = 4,
  parameter int TAGw    = 3
) (
  input  logic               clk,
  input  logic               reset,
  int_ctrl_wb_if.slave       wb,
  input  logic [INT_NUM-1:0] irq_i,
  output logic               irq_o
);

  localparam int IDXW = idx_width(INT_NUM);

  logic               mer;
  logic [INT_NUM-1:0] ier;
  logic [INT_NUM-1:0] edge_mode;
  logic [INT_NUM-1:0] pending;
  logic [INT_NUM-1:0] irq_q;
  logic [INT_NUM-1:0] set_evt;
  logic [INT_NUM-1:0] iar_clr;
  logic [INT_NUM-1:0] vec_clr;
  logic [INT_NUM-1:0] pending_next;
  logic [Dw-1:0]      vec_rd;
  logic [Dw-1:0]      rd_data;
  logic               wr_en;
  logic               rd_en;

  // Byte selects, tag and cyc carry no meaning here; full-word access only.
  logic unused_wb;
  assign unused_wb = ^{wb.sa_sel_i, wb.sa_tag_i, wb.sa_cyc_i, wb.sa_dat_i};

  assign wb.sa_err_o = 1'b0;
  assign wb.sa_rty_o = 1'b0;

  assign wr_en = wb.sa_stb_i &  wb.sa_we_i & ~wb.sa_ack_o;
  assign rd_en = wb.sa_stb_i & ~wb.sa_we_i & ~wb.sa_ack_o;

  // Edge sources fire on 0->1 only; level sources fire whenever high.
  assign set_evt = irq_i & ~(edge_mode & irq_q);

  assign iar_clr = (wr_en && wb.sa_addr_i == Aw'(REG_IAR))
                   ? wb.sa_dat_i[INT_NUM-1:0] : '0;

`ifdef INT_CTRL_VECTOR_EN
  logic [IDXW-1:0] vec_idx;
  logic            vec_valid;

  int_prio_enc #(
    .N    (INT_NUM),
    .IDXW (IDXW)
  ) u_prio_enc (
    .req   (pending & ier),
    .idx   (vec_idx),
    .valid (vec_valid)
  );

  always_comb begin
    vec_clr = '0;
    if (wr_en && wb.sa_addr_i == Aw'(REG_VEC) && wb.sa_dat_i < Dw'(INT_NUM))
      vec_clr = INT_NUM'(1) << wb.sa_dat_i;
    vec_rd = vec_valid ? Dw'(vec_idx) : (Dw'(1) << vec_none_bit(Dw));
  end
`else
  assign vec_clr = '0;
  assign vec_rd  = '0;
`endif

  // A set event in the same cycle as a clear wins, so no event is lost.
  assign pending_next = (pending & ~(iar_clr | vec_clr)) | set_evt;

  always_comb begin
    rd_data = '0;
    case (wb.sa_addr_i)
      Aw'(REG_MER):  rd_data = Dw'(mer);
      Aw'(REG_IER):  rd_data = Dw'(ier);
      Aw'(REG_IPR):  rd_data = Dw'(pending);
      Aw'(REG_EDGE): rd_data = Dw'(edge_mode);
      Aw'(REG_VEC):  rd_data = vec_rd;
      default:       rd_data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mer         <= 1'b0;
      ier         <= '0;
      edge_mode   <= '0;
      pending     <= '0;
      irq_q       <= '0;
      irq_o       <= 1'b0;
      wb.sa_ack_o <= 1'b0;
      wb.sa_dat_o <= '0;
    end else begin
      irq_q       <= irq_i;
      pending     <= pending_next;
      irq_o       <= mer & |(pending_next & ier);
      wb.sa_ack_o <= wb.sa_stb_i & ~wb.sa_ack_o;
      if (rd_en)
        wb.sa_dat_o <= rd_data;
      if (wr_en) begin
        case (wb.sa_addr_i)
          Aw'(REG_MER):  mer       <= wb.sa_dat_i[0];
          Aw'(REG_IER):  ier       <= wb.sa_dat_i[INT_NUM-1:0];
          Aw'(REG_EDGE): edge_mode <= wb.sa_dat_i[INT_NUM-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl_wb.sv
// Directed scoreboard bench for int_ctrl_wb (also covers the INT_CTRL_VECTOR_EN build).
`timescale 1ns/1ps
module tb_int_ctrl_wb;
  import int_ctrl_wb_pkg::*;

  localparam int INT_NUM = 8;
  localparam int DW      = 32;
  localparam int AW      = 3;
  localparam int SELW    = 4;
  localparam int TAGW    = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [INT_NUM-1:0] irq_i;
  logic               irq_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  int_ctrl_wb_if #(.Dw(DW), .Aw(AW), .SELw(SELW), .TAGw(TAGW)) wb ();

  int_ctrl_wb #(
    .INT_NUM (INT_NUM),
    .Dw      (DW),
    .Aw      (AW),
    .SELw    (SELW),
    .TAGw    (TAGW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb),
    .irq_i (irq_i),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus access; a read pops its expected value when the ack arrives.
  task automatic xfer(input logic we, input logic [2:0] addr, input logic [31:0] wdata);
    int n;
    wb.sa_stb_i  = 1'b1;
    wb.sa_cyc_i  = 1'b1;
    wb.sa_we_i   = we;
    wb.sa_addr_i = addr;
    wb.sa_dat_i  = wdata;
    wb.sa_sel_i  = '1;
    n = 0;
    do begin
      tick();
      n++;
    end while (wb.sa_ack_o !== 1'b1 && n < 8);
    check($sformatf("ack_latency a%0d", addr), 32'(n), 32'd1);
    if (!we) begin
      logic [31:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, wb.sa_dat_o, e);
    end
    wb.sa_stb_i = 1'b0;
    wb.sa_cyc_i = 1'b0;
    wb.sa_we_i  = 1'b0;
    tick();
    check("ack_drop", 32'(wb.sa_ack_o), 32'd0);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    xfer(1'b1, addr, data);
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    xfer(1'b0, addr, 32'h0);
  endtask

  initial begin
    logic [31:0] rst_exp;
    reset        = 1'b1;
    irq_i        = '0;
    wb.sa_stb_i  = 1'b0;
    wb.sa_cyc_i  = 1'b0;
    wb.sa_we_i   = 1'b0;
    wb.sa_addr_i = '0;
    wb.sa_dat_i  = '0;
    wb.sa_sel_i  = '0;
    wb.sa_tag_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq_o", 32'(irq_o), 32'd0);
    check("rst_ack", 32'(wb.sa_ack_o), 32'd0);
    check("rst_dat_o", wb.sa_dat_o, 32'd0);
    reset = 1'b0;
    tick();

    // Every address reads back its reset value.
    for (int a = 0; a < 8; a++) begin
      rst_exp = 32'h0;
`ifdef INT_CTRL_VECTOR_EN
      if (a == 5) rst_exp = 32'h8000_0000;
`endif
      rd(3'(a), rst_exp, $sformatf("rst_read a%0d", a));
    end
    check("rst_irq_o_after_reads", 32'(irq_o), 32'd0);

    // Single-cycle pulse on source 0, level mode.
    wr(REG_MER, 32'h1);
    wr(REG_IER, 32'h01);
    wr(REG_EDGE, 32'h0);
    irq_i[0] = 1'b1;
    check("irq_before_edge", 32'(irq_o), 32'd0);
    tick();
    check("irq_one_cycle", 32'(irq_o), 32'd1);
    irq_i[0] = 1'b0;
    tick();
    check("irq_held", 32'(irq_o), 32'd1);
    rd(REG_IPR, 32'h01, "ipr_src0");
    wr(REG_IAR, 32'h01);
    rd(REG_IPR, 32'h00, "ipr_src0_acked");
    check("irq_after_ack", 32'(irq_o), 32'd0);

    // Level mode: acking while the line is high re-pends.
    wr(REG_IER, 32'h04);
    irq_i[2] = 1'b1;
    tick();
    wr(REG_IAR, 32'h04);
    rd(REG_IPR, 32'h04, "level_repend");
    check("level_irq_high", 32'(irq_o), 32'd1);
    irq_i[2] = 1'b0;
    tick();
    wr(REG_IAR, 32'h04);
    rd(REG_IPR, 32'h00, "level_cleared");
    check("level_irq_low", 32'(irq_o), 32'd0);

    // Edge mode on source 3: a held line does not retrigger.
    wr(REG_EDGE, 32'h08);
    irq_i[3] = 1'b1;
    repeat (10) tick();
    rd(REG_IPR, 32'h08, "edge_set");
    wr(REG_IAR, 32'h08);
    rd(REG_IPR, 32'h00, "edge_no_retrigger");
    irq_i[3] = 1'b0;
    tick();
    irq_i[3] = 1'b1;
    tick();
    irq_i[3] = 1'b0;
    tick();
    // Rising edge lands on the same clock as the IAR write commit.
    irq_i[3] = 1'b1;
    wr(REG_IAR, 32'h08);
    rd(REG_IPR, 32'h08, "edge_set_wins");
    irq_i[3] = 1'b0;
    wr(REG_IAR, 32'h08);
    rd(REG_IPR, 32'h00, "edge_final_clear");

    // Masking: pending latches regardless of IER/MER.
    wr(REG_EDGE, 32'h0);
    wr(REG_IER, 32'h0);
    irq_i[5] = 1'b1;
    tick();
    irq_i[5] = 1'b0;
    tick();
    check("mask_ier_irq", 32'(irq_o), 32'd0);
    rd(REG_IPR, 32'h20, "mask_pending");
    wr(REG_MER, 32'h0);
    wr(REG_IER, 32'h20);
    check("mask_mer_irq", 32'(irq_o), 32'd0);
    rd(REG_IER, 32'h20, "ier_readback");
    rd(REG_MER, 32'h0, "mer_readback");
    wr(REG_MER, 32'h1);
    check("unmask_irq", 32'(irq_o), 32'd1);

    // Read-only and unmapped addresses ignore writes.
    wr(REG_IPR, 32'h0);
    rd(REG_IPR, 32'h20, "ipr_write_ignored");
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'h0, "addr6_zero");
    rd(3'd7, 32'h0, "addr7_zero");
    rd(REG_IAR, 32'h0, "iar_reads_zero");
    wr(REG_EDGE, 32'hFFFF_FF00);
    rd(REG_EDGE, 32'h0, "edge_upper_bits_zero");

`ifdef INT_CTRL_VECTOR_EN
    // Vectored readout and clear.
    wr(REG_IER, 32'hFF);
    irq_i[3] = 1'b1;
    tick();
    irq_i[3] = 1'b0;
    tick();
    rd(REG_IPR, 32'h28, "vec_pending");
    rd(REG_VEC, 32'h3, "vec_lowest");
    wr(REG_VEC, 32'h9);
    rd(REG_IPR, 32'h28, "vec_out_of_range_ignored");
    wr(REG_VEC, 32'h3);
    rd(REG_VEC, 32'h5, "vec_after_clear");
    wr(REG_IAR, 32'h20);
    rd(REG_VEC, 32'h8000_0000, "vec_none");
    check("vec_irq_low", 32'(irq_o), 32'd0);
`else
    // Without the vector feature, VEC is inert.
    wr(REG_VEC, 32'h5);
    rd(REG_IPR, 32'h20, "vec_write_ignored");
    rd(REG_VEC, 32'h0, "vec_reads_zero");
`endif

    // Asynchronous reset in the middle of an access.
    wb.sa_stb_i  = 1'b1;
    wb.sa_cyc_i  = 1'b1;
    wb.sa_we_i   = 1'b0;
    wb.sa_addr_i = REG_IER;
    tick();
    check("mid_ack_before_reset", 32'(wb.sa_ack_o), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_ack", 32'(wb.sa_ack_o), 32'd0);
    check("mid_reset_dat", wb.sa_dat_o, 32'd0);
    check("mid_reset_irq", 32'(irq_o), 32'd0);
    wb.sa_stb_i = 1'b0;
    wb.sa_cyc_i = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    rd(REG_IPR, 32'h0, "post_reset_ipr");
    rd(REG_IER, 32'h0, "post_reset_ier");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
